// File: rtl/vend_if.sv
// Coin-acceptor / dispenser bundle for the vending controller.
// The bench or acceptor side drives through master; the controller uses slave.
interface vend_if #(
  parameter int unsigned CREDIT_W = 9,
  parameter int unsigned STOCK_W  = 8
);
  logic                coin_n;
  logic                coin_d;
  logic                coin_q;
  logic                cancel;
  logic                restock;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                vend;
  logic                chg_n;
  logic                chg_d;
  logic                chg_q;
  logic                coin_rej;
  logic                busy;
  logic                sold_out;

  modport master (
    output coin_n, coin_d, coin_q, cancel, restock,
    input  credit, stock, vend, chg_n, chg_d, chg_q, coin_rej, busy, sold_out
  );

  modport slave (
    input  coin_n, coin_d, coin_q, cancel, restock,
    output credit, stock, vend, chg_n, chg_d, chg_q, coin_rej, busy, sold_out
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Vending controller: accumulates nickel/dime/quarter credit, vends at PRICE,
// and pays change or refunds one coin per cycle, largest denomination first.
module vend_ctrl_param #(
  parameter int unsigned PRICE      = 65,
  parameter int unsigned CREDIT_W   = 9,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned STOCK_W    = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  vend_if.slave  bus
);

  if ((PRICE + 20) >= (1 << CREDIT_W)) begin : g_bad_credit_w
    $error("vend_ctrl_param: CREDIT_W=%0d cannot hold PRICE+20=%0d", CREDIT_W, PRICE + 20);
  end
  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 255) begin : g_bad_price
    $error("vend_ctrl_param: PRICE=%0d must be a multiple of 5 in 5..255", PRICE);
  end
  if (STOCK_INIT < 1 || STOCK_INIT >= (1 << STOCK_W)) begin : g_bad_stock
    $error("vend_ctrl_param: STOCK_INIT=%0d does not fit STOCK_W=%0d", STOCK_INIT, STOCK_W);
  end

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] N_V   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] D_V   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] Q_V   = CREDIT_W'(25);
  localparam logic [CREDIT_W:0]   PRC_X = (CREDIT_W+1)'(PRICE);
  localparam logic [STOCK_W-1:0]  STK_I = STOCK_W'(STOCK_INIT);

  typedef struct packed {
    logic n;
    logic d;
    logic q;
    logic cancel;
    logic restock;
  } req_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_q, credit_nx;
  logic [STOCK_W-1:0]  stock_q, stock_nx;
  logic                rej_q, rej_nx;
  req_t                req;
  logic                any_coin, one_coin, coin_ok, sold_out;
  logic [CREDIT_W-1:0] coin_val, chg_val;
  logic [CREDIT_W:0]   sum;
  logic                sel_q, sel_d, sel_n;

  assign req = '{n: bus.coin_n, d: bus.coin_d, q: bus.coin_q,
                 cancel: bus.cancel, restock: bus.restock};

  assign sold_out = (stock_q == '0);
  assign any_coin = req.n | req.d | req.q;
  assign one_coin = (req.n ^ req.d ^ req.q) & ~(req.n & req.d & req.q);
  assign coin_ok  = one_coin & (state == ACCEPT) & ~sold_out;

  always_comb begin
    coin_val = '0;
    if (req.n)      coin_val = N_V;
    else if (req.d) coin_val = D_V;
    else if (req.q) coin_val = Q_V;
  end

  assign sum = {1'b0, credit_q} + {1'b0, coin_val};

  // Change denomination comes from registered credit, so the chg_* pulses
  // have no path back to the coin inputs.
  assign sel_q = (state == CHANGE) && (credit_q >= Q_V);
  assign sel_d = (state == CHANGE) && !sel_q && (credit_q >= D_V);
  assign sel_n = (state == CHANGE) && !sel_q && !sel_d;

  always_comb begin
    chg_val = N_V;
    if (sel_q)      chg_val = Q_V;
    else if (sel_d) chg_val = D_V;
  end

  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    stock_nx  = stock_q;
    rej_nx    = any_coin & ~coin_ok;
    case (state)
      ACCEPT: begin
        if (coin_ok) begin
          if (req.cancel) begin
            credit_nx = sum[CREDIT_W-1:0];
            state_nx  = CHANGE;
          end else if (sum >= PRC_X) begin
            credit_nx = CREDIT_W'(sum - PRC_X);
            state_nx  = VEND;
          end else begin
            credit_nx = sum[CREDIT_W-1:0];
          end
        end else if (req.cancel && credit_q != '0) begin
          state_nx = CHANGE;
        end
      end
      VEND: begin
        stock_nx = stock_q - STOCK_W'(1);
        state_nx = (credit_q != '0) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        credit_nx = credit_q - chg_val;
        if (credit_nx == '0) state_nx = ACCEPT;
      end
      default: begin
        state_nx  = ACCEPT;
        credit_nx = '0;
      end
    endcase
    // Restock overrides the vend decrement landing on the same edge.
    if (req.restock) stock_nx = STK_I;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ACCEPT;
      credit_q <= '0;
      stock_q  <= STK_I;
      rej_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      credit_q <= credit_nx;
      stock_q  <= stock_nx;
      rej_q    <= rej_nx;
    end
  end

  assign bus.credit   = credit_q;
  assign bus.stock    = stock_q;
  assign bus.vend     = (state == VEND);
  assign bus.chg_q    = sel_q;
  assign bus.chg_d    = sel_d;
  assign bus.chg_n    = sel_n;
  assign bus.coin_rej = rej_q;
  assign bus.busy     = (state != ACCEPT);
  assign bus.sold_out = sold_out;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: queue-of-events reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vend_ctrl_param;
  localparam int unsigned PRICE      = 65;
  localparam int unsigned CREDIT_W   = 9;
  localparam int unsigned STOCK_INIT = 2;
  localparam int unsigned STOCK_W    = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   run_cmp = 1'b0;
  bit   mon_on = 1'b0;
  int   chg_d_seen = 0;

  vend_if #(.CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W)) bus ();

  vend_ctrl_param #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .STOCK_INIT(STOCK_INIT), .STOCK_W(STOCK_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Model: pending output events (0 = vend, else a change coin value).
  int m_credit;
  int m_stock;
  bit m_rej;
  int evq[$];

  task automatic refund(input int amt);
    int a;
    a = amt;
    while (a >= 25) begin evq.push_back(25); a -= 25; end
    while (a >= 10) begin evq.push_back(10); a -= 10; end
    while (a >= 5)  begin evq.push_back(5);  a -= 5;  end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_credit = 0;
      m_stock  = STOCK_INIT;
      m_rej    = 1'b0;
      evq.delete();
    end else begin : upd
      int cv, nc, sum, ev;
      bit nrej;
      nc = int'(bus.coin_n) + int'(bus.coin_d) + int'(bus.coin_q);
      cv = bus.coin_n ? 5 : bus.coin_d ? 10 : bus.coin_q ? 25 : 0;
      nrej = (nc > 0) && !(nc == 1 && evq.size() == 0 && m_stock > 0);
      if (evq.size() > 0) begin
        ev = evq.pop_front();
        if (ev == 0) m_stock = m_stock - 1;
        else m_credit = m_credit - ev;
      end else if (nc == 1 && m_stock > 0) begin
        sum = m_credit + cv;
        if (bus.cancel) begin
          m_credit = sum;
          refund(sum);
        end else if (sum >= int'(PRICE)) begin
          m_credit = sum - int'(PRICE);
          evq.push_back(0);
          refund(m_credit);
        end else begin
          m_credit = sum;
        end
      end else if (bus.cancel && m_credit > 0) begin
        refund(m_credit);
      end
      if (bus.restock) m_stock = STOCK_INIT;
      m_rej = nrej;
    end
  end

  always @(negedge clk) begin
    if (run_cmp && reset_n) begin : cmp
      logic [6:0] exp_v, act_v;
      int hd;
      hd = (evq.size() > 0) ? evq[0] : -1;
      exp_v = {hd == 0, hd == 5, hd == 10, hd == 25, m_rej, evq.size() > 0, m_stock == 0};
      act_v = {bus.vend, bus.chg_n, bus.chg_d, bus.chg_q, bus.coin_rej, bus.busy, bus.sold_out};
      chk("pulses{vend,n,d,q,rej,busy,sold}", 32'(act_v), 32'(exp_v));
      chk("credit", 32'(bus.credit), m_credit);
      chk("stock", 32'(bus.stock), m_stock);
    end
    if (mon_on && bus.chg_d) chg_d_seen++;
  end

  // Drive one cycle of inputs starting just after a falling edge; returns at
  // the next falling edge with inputs cleared.
  task automatic cyc(input bit n, input bit d, input bit q, input bit c, input bit r);
    bus.coin_n = n; bus.coin_d = d; bus.coin_q = q; bus.cancel = c; bus.restock = r;
    @(negedge clk);
    bus.coin_n = 0; bus.coin_d = 0; bus.coin_q = 0; bus.cancel = 0; bus.restock = 0;
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.coin_n = 0; bus.coin_d = 0; bus.coin_q = 0; bus.cancel = 0; bus.restock = 0;
    repeat (2) @(negedge clk);
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_stock", 32'(bus.stock), 2);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_vend", 32'(bus.vend), 0);
    #1 reset_n = 1'b1;
    run_cmp = 1'b1;

    // Q,Q,D,N -> exact price
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,1,0,0,0); cyc(1,0,0,0,0);
    chk("t1_vend", 32'(bus.vend), 1);
    chk("t1_credit", 32'(bus.credit), 0);
    idle(1);
    chk("t1_stock", 32'(bus.stock), 1);
    chk("t1_nochg", 32'({bus.chg_n, bus.chg_d, bus.chg_q}), 0);

    // Q,Q,D,Q -> 85: vend then two dimes; a nickel during VEND is rejected
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,1,0,0,0); cyc(0,0,1,0,0);
    chk("t2_vend", 32'(bus.vend), 1);
    chk("t2_credit", 32'(bus.credit), 20);
    cyc(1,0,0,0,0);
    chk("t2_chg_d1", 32'(bus.chg_d), 1);
    chk("t2_rej_busy", 32'(bus.coin_rej), 1);
    idle(1);
    chk("t2_chg_d2", 32'(bus.chg_d), 1);
    chk("t2_busy", 32'(bus.busy), 1);
    idle(1);
    chk("t2_busy_fall", 32'(bus.busy), 0);
    chk("t2_credit_end", 32'(bus.credit), 0);

    // sold out, then restock
    chk("t5_sold", 32'(bus.sold_out), 1);
    cyc(0,0,1,0,0);
    chk("t5_rej", 32'(bus.coin_rej), 1);
    chk("t5_credit", 32'(bus.credit), 0);
    cyc(0,0,0,0,1);
    chk("t5_stock", 32'(bus.stock), 2);
    chk("t5_sold0", 32'(bus.sold_out), 0);
    cyc(0,0,1,0,0);
    chk("t5_credit25", 32'(bus.credit), 25);

    // 35 refunded as Q then D
    cyc(0,1,0,0,0);
    cyc(0,0,0,1,0);
    chk("refund_q", 32'(bus.chg_q), 1);
    chk("refund_novend", 32'(bus.vend), 0);
    idle(1);
    chk("refund_d", 32'(bus.chg_d), 1);
    idle(1);
    chk("refund_done", 32'(bus.busy), 0);

    // cancel with zero credit is ignored
    cyc(0,0,0,1,0);
    chk("cancel0_busy", 32'(bus.busy), 0);

    // D then cancel
    cyc(0,1,0,0,0); cyc(0,0,0,1,0);
    chk("t3_chg_d", 32'(bus.chg_d), 1);
    idle(1);
    chk("t3_chg_d_once", 32'(bus.chg_d), 0);
    chk("t3_novend", 32'(bus.vend), 0);
    chk("t3_credit", 32'(bus.credit), 0);

    // two coins at once
    cyc(1,1,0,0,0);
    chk("t4_rej", 32'(bus.coin_rej), 1);
    chk("t4_credit", 32'(bus.credit), 0);

    // coin + cancel at/over price: full 75 refunded, no vend
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,1,1,0);
    chk("cc_chg_q", 32'(bus.chg_q), 1);
    chk("cc_novend", 32'(bus.vend), 0);
    chk("cc_credit", 32'(bus.credit), 75);
    idle(3);
    chk("cc_done", 32'(bus.busy), 0);

    // restock coinciding with the vend decrement
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,1,0,0,0); cyc(1,0,0,0,0);
    chk("rv_vend", 32'(bus.vend), 1);
    cyc(0,0,0,0,1);
    chk("rv_stock", 32'(bus.stock), 2);

    // reset as CHANGE begins
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,1,0,0);
    chk("t6_vend", 32'(bus.vend), 1);
    mon_on = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_chg_d", 32'(bus.chg_d), 0);
    chk("t6_credit", 32'(bus.credit), 0);
    chk("t6_stock", 32'(bus.stock), 2);
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    chk("t6_chg_d_never", chg_d_seen, 0);
    chk("t6_idle_busy", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
